bip_acc_datapath_ext: RTL and testbench

//   Parametrised accumulator datapath for the next-generation BIP core. Holds the ACC register,

---
 rtl/bip_acc_datapath_ext.sv | 222 ++++++++++++++++++++++
 tb/tb_bip_acc_datapath_ext.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_acc_datapath_ext.sv
// -----------------------------------------------------------------------------
// bip_acc_datapath_ext
//   Accumulator datapath for the BIP core. Holds the ACC register, sign-extends
//   the instruction operand, runs the ALU (ADD/SUB/AND/OR/XOR/PASSB) and a
//   one-bit-per-cycle serial shifter (SHL/SRA). Keeps the {Z,N,C,V} flags and
//   signals completion with a busy/done handshake.
//
// Ports
//   i_clock     clock, rising edge
//   i_reset     asynchronous active-low reset
//   i_valid     command strobe
//   i_wr_acc    command writes ACC (commands without it are ignored)
//   i_sel_a     ACC source: 0 mem, 1 ext operand, 2 ALU, 3 hold
//   i_sel_b     ALU B operand: 1 ext operand, 0 i_data_mem
//   i_op        ALU opcode: ADD SUB AND OR XOR SHL SRA PASSB
//   i_operand   instruction operand (two's complement)
//   i_data_mem  data-memory read data
//   o_data      ACC value
//   o_flags     {Z,N,C,V}
//   o_busy      serial shift in progress
//   o_done      one-cycle pulse when a command's ACC update completes
//
// NB_OPERAND must not exceed NB_DATA, and NB_SHAMT must equal clog2(NB_DATA).
// -----------------------------------------------------------------------------
module bip_acc_datapath_ext #(
  parameter int NB_DATA    = 16,
  parameter int NB_OPERAND = 11,
  parameter int NB_SEL_A   = 2,
  parameter int NB_OP      = 3,
  parameter int NB_SHAMT   = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_wr_acc,
  input  logic [NB_SEL_A-1:0]   i_sel_a,
  input  logic                  i_sel_b,
  input  logic [NB_OP-1:0]      i_op,
  input  logic [NB_OPERAND-1:0] i_operand,
  input  logic [NB_DATA-1:0]    i_data_mem,
  output logic [NB_DATA-1:0]    o_data,
  output logic [3:0]            o_flags,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [NB_SEL_A-1:0] SEL_MEM = NB_SEL_A'(0);
  localparam logic [NB_SEL_A-1:0] SEL_EXT = NB_SEL_A'(1);
  localparam logic [NB_SEL_A-1:0] SEL_ALU = NB_SEL_A'(2);

  localparam logic [NB_OP-1:0] OP_ADD   = NB_OP'(0);
  localparam logic [NB_OP-1:0] OP_SUB   = NB_OP'(1);
  localparam logic [NB_OP-1:0] OP_AND   = NB_OP'(2);
  localparam logic [NB_OP-1:0] OP_OR    = NB_OP'(3);
  localparam logic [NB_OP-1:0] OP_XOR   = NB_OP'(4);
  localparam logic [NB_OP-1:0] OP_SHL   = NB_OP'(5);
  localparam logic [NB_OP-1:0] OP_SRA   = NB_OP'(6);
  localparam logic [NB_OP-1:0] OP_PASSB = NB_OP'(7);

  localparam logic [NB_SHAMT-1:0] CNT_ONE = NB_SHAMT'(1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  // state
  state_t              state_reg;
  logic [NB_DATA-1:0]  acc_reg;
  logic                z_reg;
  logic                n_reg;
  logic                c_reg;
  logic                v_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [NB_SHAMT-1:0] count_reg;
  logic                dir_sra_reg;

  // datapath
  logic [NB_DATA-1:0]  ext_operand;
  logic [NB_DATA-1:0]  operand_b;
  logic [NB_DATA:0]    sum_ext;
  logic [NB_DATA:0]    diff_ext;
  logic [NB_DATA-1:0]  alu_result;
  logic                alu_carry;
  logic                alu_ovf;
  logic                alu_cv_upd;
  logic [NB_DATA-1:0]  acc_wr_data;
  logic                acc_wr_en;
  logic [NB_SHAMT-1:0] shamt;
  logic                accept;
  logic                is_shift_op;
  logic                start_shift;
  logic [NB_DATA-1:0]  shift_result;
  logic                shift_out;

  // Sign extension: low bits copy the operand, upper bits replicate its MSB.
  genvar gi;
  generate
    for (gi = 0; gi < NB_DATA; gi++) begin : g_ext
      if (gi < NB_OPERAND) begin : g_copy
        assign ext_operand[gi] = i_operand[gi];
      end else begin : g_sign
        assign ext_operand[gi] = i_operand[NB_OPERAND-1];
      end
    end
  endgenerate

  assign operand_b = i_sel_b ? ext_operand : i_data_mem;
  assign sum_ext   = {1'b0, acc_reg} + {1'b0, operand_b};
  assign diff_ext  = {1'b0, acc_reg} - {1'b0, operand_b};
  assign shamt     = operand_b[NB_SHAMT-1:0];

  always_comb begin
    alu_result = acc_reg;
    alu_carry  = c_reg;
    alu_ovf    = v_reg;
    alu_cv_upd = 1'b0;
    case (i_op)
      OP_ADD: begin
        alu_result = sum_ext[NB_DATA-1:0];
        alu_carry  = sum_ext[NB_DATA];
        alu_ovf    = (acc_reg[NB_DATA-1] == operand_b[NB_DATA-1]) &&
                     (sum_ext[NB_DATA-1] != acc_reg[NB_DATA-1]);
        alu_cv_upd = 1'b1;
      end
      OP_SUB: begin
        alu_result = diff_ext[NB_DATA-1:0];
        // Extended MSB set means a borrow occurred; C reports "no borrow".
        alu_carry  = ~diff_ext[NB_DATA];
        alu_ovf    = (acc_reg[NB_DATA-1] != operand_b[NB_DATA-1]) &&
                     (diff_ext[NB_DATA-1] != acc_reg[NB_DATA-1]);
        alu_cv_upd = 1'b1;
      end
      OP_AND:   alu_result = acc_reg & operand_b;
      OP_OR:    alu_result = acc_reg | operand_b;
      OP_XOR:   alu_result = acc_reg ^ operand_b;
      OP_PASSB: alu_result = operand_b;
      // Shifts only reach this path with a zero amount, so ACC passes through.
      default:  alu_result = acc_reg;
    endcase
  end

  always_comb begin
    acc_wr_en   = 1'b1;
    acc_wr_data = acc_reg;
    case (i_sel_a)
      SEL_MEM: acc_wr_data = i_data_mem;
      SEL_EXT: acc_wr_data = ext_operand;
      SEL_ALU: acc_wr_data = alu_result;
      default: acc_wr_en   = 1'b0;
    endcase
  end

  assign accept      = i_valid & i_wr_acc & ~busy_reg;
  assign is_shift_op = (i_sel_a == SEL_ALU) && ((i_op == OP_SHL) || (i_op == OP_SRA));
  assign start_shift = is_shift_op && (shamt != '0);

  assign shift_result = dir_sra_reg ? {acc_reg[NB_DATA-1], acc_reg[NB_DATA-1:1]}
                                    : {acc_reg[NB_DATA-2:0], 1'b0};
  assign shift_out    = dir_sra_reg ? acc_reg[0] : acc_reg[NB_DATA-1];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg   <= ST_IDLE;
      acc_reg     <= '0;
      z_reg       <= 1'b0;
      n_reg       <= 1'b0;
      c_reg       <= 1'b0;
      v_reg       <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      count_reg   <= '0;
      dir_sra_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (start_shift) begin
              // ACC is untouched on the accept edge; stepping starts next edge.
              count_reg   <= shamt;
              dir_sra_reg <= (i_op == OP_SRA);
              state_reg   <= ST_SHIFT;
              busy_reg    <= 1'b1;
            end else begin
              done_reg <= 1'b1;
              if (acc_wr_en) begin
                acc_reg <= acc_wr_data;
                z_reg   <= (acc_wr_data == '0);
                n_reg   <= acc_wr_data[NB_DATA-1];
              end
              if ((i_sel_a == SEL_ALU) && alu_cv_upd) begin
                c_reg <= alu_carry;
                v_reg <= alu_ovf;
              end
            end
          end
        end
        ST_SHIFT: begin
          acc_reg   <= shift_result;
          c_reg     <= shift_out;
          z_reg     <= (shift_result == '0);
          n_reg     <= shift_result[NB_DATA-1];
          count_reg <= count_reg - CNT_ONE;
          if (count_reg == CNT_ONE) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_data  = acc_reg;
  assign o_flags = {z_reg, n_reg, c_reg, v_reg};
  assign o_busy  = busy_reg;
  assign o_done  = done_reg;

endmodule

// File: tb/tb_bip_acc_datapath_ext.sv
// -----------------------------------------------------------------------------
// tb_bip_acc_datapath_ext
//   Self-checking bench for bip_acc_datapath_ext with a behavioural model that
//   computes each command's final ACC/flags and expected shift length directly
//   from integer arithmetic.
// -----------------------------------------------------------------------------
module tb_bip_acc_datapath_ext;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_wr_acc = 1'b0;
  logic [1:0]  i_sel_a = 2'd3;
  logic        i_sel_b = 1'b0;
  logic [2:0]  i_op = 3'd0;
  logic [10:0] i_operand = 11'd0;
  logic [15:0] i_data_mem = 16'd0;
  logic [15:0] o_data;
  logic [3:0]  o_flags;
  logic        o_busy;
  logic        o_done;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [15:0] m_acc = 16'd0;
  logic        m_z = 1'b0;
  logic        m_n = 1'b0;
  logic        m_c = 1'b0;
  logic        m_v = 1'b0;
  int          m_k = 0;

  bip_acc_datapath_ext dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_wr_acc   (i_wr_acc),
    .i_sel_a    (i_sel_a),
    .i_sel_b    (i_sel_b),
    .i_op       (i_op),
    .i_operand  (i_operand),
    .i_data_mem (i_data_mem),
    .o_data     (o_data),
    .o_flags    (o_flags),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clock = ~i_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_acc = 16'd0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0; m_k = 0;
  endtask

  // Final outcome of one accepted command.
  task automatic model_apply(input logic [1:0] sa, input logic sb, input logic [2:0] op,
                             input logic [10:0] opnd, input logic [15:0] mem);
    int a, b, r, e, as, bs, sr, k;
    e = opnd[10] ? int'(opnd) - 2048 : int'(opnd);
    e = e & 32'hFFFF;
    a = int'(m_acc);
    b = sb ? e : int'(mem);
    as = (a >= 32768) ? a - 65536 : a;
    bs = (b >= 32768) ? b - 65536 : b;
    m_k = 0;
    r = a;
    if (sa == 2'd3) return;
    case (sa)
      2'd0: r = int'(mem);
      2'd1: r = e;
      default: begin
        case (op)
          3'd0: begin
            r = a + b; m_c = (r > 65535);
            sr = as + bs; m_v = (sr > 32767) || (sr < -32768);
          end
          3'd1: begin
            r = a - b; m_c = (a >= b);
            sr = as - bs; m_v = (sr > 32767) || (sr < -32768);
          end
          3'd2: r = a & b;
          3'd3: r = a | b;
          3'd4: r = a ^ b;
          3'd5: begin
            k = b % 16;
            if (k > 0) begin
              r = a << k; m_c = ((a >> (16 - k)) & 1) == 1; m_k = k;
            end
          end
          3'd6: begin
            k = b % 16;
            if (k > 0) begin
              r = as >>> k; m_c = ((a >> (k - 1)) & 1) == 1; m_k = k;
            end
          end
          default: r = b;
        endcase
      end
    endcase
    r = r & 32'hFFFF;
    m_acc = r[15:0];
    m_z = (r == 0);
    m_n = r[15];
  endtask

  // Drive one command, then follow it to o_done (bounded).
  // lat = samples after the accept edge up to and including the done sample.
  task automatic run_cmd(input logic [1:0] sa, input logic sb, input logic [2:0] op,
                         input logic [10:0] opnd, input logic [15:0] mem,
                         output int lat, output int busy_n, output logic done_after);
    @(negedge i_clock);
    i_valid = 1'b1; i_wr_acc = 1'b1;
    i_sel_a = sa; i_sel_b = sb; i_op = op; i_operand = opnd; i_data_mem = mem;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    lat = 1; busy_n = 0;
    while (!o_done && lat < 40) begin
      if (o_busy) busy_n++;
      @(posedge i_clock); #1;
      lat++;
    end
    @(posedge i_clock); #1;
    done_after = o_done;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    #3;
    checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", o_data); end
    checks++; if (o_flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", o_flags); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b1;
    model_reset();
    $display("reset: data=%h flags=%b busy=%b done=%b", o_data, o_flags, o_busy, o_done);
  endtask

  task automatic test_load_ext();
    int lat, busy_n; logic da;
    model_apply(2'd1, 1'b1, 3'd0, 11'h7FF, 16'h0);
    run_cmd(2'd1, 1'b1, 3'd0, 11'h7FF, 16'h0, lat, busy_n, da);
    checks++; if (o_data !== 16'hFFFF) begin errors++; $display("FAIL load_ext_data: got %h want ffff", o_data); end
    checks++; if (o_flags[3:2] !== 2'b01) begin errors++; $display("FAIL load_ext_zn: got %b want 01", o_flags[3:2]); end
    checks++; if (o_flags !== {m_z, m_n, m_c, m_v}) begin errors++; $display("FAIL load_ext_flags: got %b want %b", o_flags, {m_z, m_n, m_c, m_v}); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL load_ext_latency: got %0d want 1", lat); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL load_ext_done_width: done still %b", da); end
    $display("load ext 7ff: data=%h flags=%b lat=%0d", o_data, o_flags, lat);
  endtask

  task automatic test_add_sub();
    int lat, busy_n; logic da;
    model_apply(2'd0, 1'b0, 3'd0, 11'h0, 16'h7FFF);
    run_cmd(2'd0, 1'b0, 3'd0, 11'h0, 16'h7FFF, lat, busy_n, da);
    model_apply(2'd2, 1'b1, 3'd0, 11'h001, 16'h0);
    run_cmd(2'd2, 1'b1, 3'd0, 11'h001, 16'h0, lat, busy_n, da);
    checks++; if (o_data !== 16'h8000) begin errors++; $display("FAIL add_data: got %h want 8000", o_data); end
    checks++; if (o_flags !== 4'b0101) begin errors++; $display("FAIL add_flags: got %b want 0101", o_flags); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
    $display("add ext 1: data=%h flags=%b", o_data, o_flags);
    model_apply(2'd2, 1'b0, 3'd1, 11'h0, 16'h8000);
    run_cmd(2'd2, 1'b0, 3'd1, 11'h0, 16'h8000, lat, busy_n, da);
    checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL sub_data: got %h want 0000", o_data); end
    checks++; if (o_flags !== 4'b1010) begin errors++; $display("FAIL sub_flags: got %b want 1010", o_flags); end
    checks++; if (o_flags !== {m_z, m_n, m_c, m_v}) begin errors++; $display("FAIL sub_model_flags: got %b want %b", o_flags, {m_z, m_n, m_c, m_v}); end
    $display("sub mem 8000: data=%h flags=%b", o_data, o_flags);
  endtask

  task automatic test_sra_busy();
    int lat, busy_n; logic da;
    model_apply(2'd0, 1'b0, 3'd0, 11'h0, 16'h8001);
    run_cmd(2'd0, 1'b0, 3'd0, 11'h0, 16'h8001, lat, busy_n, da);
    model_apply(2'd2, 1'b1, 3'd6, 11'd3, 16'h0);
    @(negedge i_clock);
    i_valid = 1'b1; i_wr_acc = 1'b1;
    i_sel_a = 2'd2; i_sel_b = 1'b1; i_op = 3'd6; i_operand = 11'd3;
    @(posedge i_clock); #1;
    // keep a load command strobing while busy; it must be ignored
    i_sel_a = 2'd1; i_operand = 11'h055;
    lat = 1; busy_n = 0;
    while (o_busy && lat < 40) begin
      busy_n++;
      @(posedge i_clock); #1;
      lat++;
    end
    i_valid = 1'b0;
    checks++; if (busy_n !== 3) begin errors++; $display("FAIL sra_busy_cycles: got %0d want 3", busy_n); end
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL sra_done: got %b want 1", o_done); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL sra_done_latency: got %0d want 4", lat); end
    checks++; if (o_data !== 16'hF000) begin errors++; $display("FAIL sra_data: got %h want f000", o_data); end
    checks++; if (o_flags[1] !== 1'b0) begin errors++; $display("FAIL sra_carry: got %b want 0", o_flags[1]); end
    checks++; if (o_flags !== {m_z, m_n, m_c, m_v}) begin errors++; $display("FAIL sra_flags: got %b want %b", o_flags, {m_z, m_n, m_c, m_v}); end
    @(posedge i_clock); #1;
    checks++; if (o_data !== 16'hF000) begin errors++; $display("FAIL sra_ignored_cmd: got %h want f000", o_data); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL sra_done_width: got %b want 0", o_done); end
    $display("sra 8001 by 3: data=%h flags=%b busy_cycles=%0d lat=%0d", o_data, o_flags, busy_n, lat);
  endtask

  task automatic test_shl_zero_xor();
    int lat, busy_n; logic da; logic [1:0] cv_prev;
    model_apply(2'd0, 1'b0, 3'd0, 11'h0, 16'h00F0);
    run_cmd(2'd0, 1'b0, 3'd0, 11'h0, 16'h00F0, lat, busy_n, da);
    model_apply(2'd2, 1'b1, 3'd5, 11'd0, 16'h0);
    run_cmd(2'd2, 1'b1, 3'd5, 11'd0, 16'h0, lat, busy_n, da);
    checks++; if (lat !== 1) begin errors++; $display("FAIL shl0_latency: got %0d want 1", lat); end
    checks++; if (busy_n !== 0) begin errors++; $display("FAIL shl0_busy: got %0d want 0", busy_n); end
    checks++; if (o_data !== 16'h00F0) begin errors++; $display("FAIL shl0_data: got %h want 00f0", o_data); end
    $display("shl 00f0 by 0: data=%h flags=%b lat=%0d", o_data, o_flags, lat);
    cv_prev = {m_c, m_v};
    model_apply(2'd2, 1'b1, 3'd4, 11'h0FF, 16'h0);
    run_cmd(2'd2, 1'b1, 3'd4, 11'h0FF, 16'h0, lat, busy_n, da);
    checks++; if (o_data !== 16'h000F) begin errors++; $display("FAIL xor_data: got %h want 000f", o_data); end
    checks++; if (o_flags[1:0] !== cv_prev) begin errors++; $display("FAIL xor_cv_hold: got %b want %b", o_flags[1:0], cv_prev); end
    checks++; if (o_flags !== {m_z, m_n, m_c, m_v}) begin errors++; $display("FAIL xor_flags: got %b want %b", o_flags, {m_z, m_n, m_c, m_v}); end
    $display("xor ext 00ff: data=%h flags=%b", o_data, o_flags);
  endtask

  task automatic test_no_wr();
    @(negedge i_clock);
    i_valid = 1'b1; i_wr_acc = 1'b0; i_sel_a = 2'd1; i_operand = 11'h123;
    @(posedge i_clock); #1;
    i_valid = 1'b0; i_wr_acc = 1'b1;
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL no_wr_done: got %b want 0", o_done); end
    checks++; if (o_data !== m_acc) begin errors++; $display("FAIL no_wr_data: got %h want %h", o_data, m_acc); end
    $display("no-wr command: data=%h done=%b", o_data, o_done);
  endtask

  task automatic test_reset_mid_shift();
    int lat, busy_n; logic da;
    model_apply(2'd0, 1'b0, 3'd0, 11'h0, 16'h0123);
    run_cmd(2'd0, 1'b0, 3'd0, 11'h0, 16'h0123, lat, busy_n, da);
    @(negedge i_clock);
    i_valid = 1'b1; i_wr_acc = 1'b1;
    i_sel_a = 2'd2; i_sel_b = 1'b1; i_op = 3'd5; i_operand = 11'd10;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    repeat (3) begin @(posedge i_clock); #1; end
    checks++; if (o_data !== 16'h0918) begin errors++; $display("FAIL midshift_data: got %h want 0918", o_data); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL midshift_busy: got %b want 1", o_busy); end
    #2;
    i_reset = 1'b0;
    #1;
    model_reset();
    checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL async_reset_data: got %h want 0000", o_data); end
    checks++; if (o_flags !== 4'b0000) begin errors++; $display("FAIL async_reset_flags: got %b want 0000", o_flags); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", o_busy); end
    @(negedge i_clock);
    i_reset = 1'b1;
    i_valid = 1'b1; i_wr_acc = 1'b1; i_sel_a = 2'd1; i_sel_b = 1'b1; i_operand = 11'h005;
    model_apply(2'd1, 1'b1, 3'd0, 11'h005, 16'h0);
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL post_reset_accept: done=%b want 1", o_done); end
    checks++; if (o_data !== 16'h0005) begin errors++; $display("FAIL post_reset_data: got %h want 0005", o_data); end
    $display("reset mid-shift: data=%h flags=%b busy=%b", o_data, o_flags, o_busy);
  endtask

  task automatic test_random();
    int lat, busy_n; logic da;
    logic [1:0] sa; logic sb; logic [2:0] op; logic [10:0] opnd; logic [15:0] mem;
    for (int i = 0; i < 80; i++) begin
      sa   = 2'($urandom_range(0, 3));
      sb   = 1'($urandom_range(0, 1));
      op   = 3'($urandom_range(0, 7));
      opnd = 11'($urandom);
      mem  = 16'($urandom);
      model_apply(sa, sb, op, opnd, mem);
      run_cmd(sa, sb, op, opnd, mem, lat, busy_n, da);
      checks++; if (o_data !== m_acc) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, o_data, m_acc); end
      checks++; if (o_flags !== {m_z, m_n, m_c, m_v}) begin errors++; $display("FAIL rand_flags[%0d]: got %b want %b", i, o_flags, {m_z, m_n, m_c, m_v}); end
      checks++; if (lat !== m_k + 1) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, m_k + 1); end
      checks++; if (busy_n !== m_k) begin errors++; $display("FAIL rand_busy[%0d]: got %0d want %0d", i, busy_n, m_k); end
      checks++; if (da !== 1'b0) begin errors++; $display("FAIL rand_done_width[%0d]: done still %b", i, da); end
      $display("rand %0d: sel_a=%0d sel_b=%0d op=%0d opnd=%h mem=%h -> data=%h flags=%b lat=%0d",
               i, sa, sb, op, opnd, mem, o_data, o_flags, lat);
    end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_add_sub();
    test_sra_busy();
    test_shl_zero_xor();
    test_no_wr();
    test_reset_mid_shift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
